// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : oversampled asynchronous serial receiver (start/DATA_BITS/stop)
// Revision: 1.0
// ============================================================================
module uart_rx #(
  parameter int BR         = 0,
  parameter int CLKF       = 0,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BAUD_TICKS = (BR > 0 && OVERSAMPLE > 0) ? BR * OVERSAMPLE : 1;
  localparam int TICK_DIV   = (BR > 0 && CLKF > 0) ? CLKF / BAUD_TICKS : 1;
  localparam int TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

  if (BR <= 0) begin : g_chk_br
    $fatal(1, "uart_rx: BR must be > 0");
  end
  if (CLKF <= 0) begin : g_chk_clkf
    $fatal(1, "uart_rx: CLKF must be > 0");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
    $fatal(1, "uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $fatal(1, "uart_rx: DATA_BITS must be 5..9");
  end
  if (BR > 0 && CLKF > 0 && ((CLKF % BAUD_TICKS) != 0 || TICK_DIV == 0)) begin : g_chk_div
    $fatal(1, "uart_rx: CLKF/(BR*OVERSAMPLE) must be an exact positive integer");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rx_s;
  state_t               state_q;
  logic [SW-1:0]        scnt_q;
  logic [BW-1:0]        bidx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  assign rx_s       = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync_q     <= 2'b11;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync_q     <= {sync_q[0], rx};
    end
  end

  // Strobes default low every clk so they last exactly one cycle after the deciding tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              scnt_q  <= '0;
            end
          end
          START: begin
            if (scnt_q == SCNT_HALF) begin
              if (!rx_s) begin
                state_q <= DATA;
                scnt_q  <= '0;
                bidx_q  <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              scnt_q <= scnt_q + SW'(1);
            end
          end
          DATA: begin
            if (scnt_q == SCNT_LAST) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              scnt_q  <= '0;
              if (bidx_q == BIDX_LAST) begin
                state_q <= STOP;
              end else begin
                bidx_q <= bidx_q + BW'(1);
              end
            end else begin
              scnt_q <= scnt_q + SW'(1);
            end
          end
          STOP: begin
            if (scnt_q == SCNT_LAST) begin
              scnt_q <= '0;
              if (rx_s) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BRK;
              end
            end else begin
              scnt_q <= scnt_q + SW'(1);
            end
          end
          BRK: begin
            if (rx_s) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx at 160 clk per bit
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

  localparam int BITCLK = 160;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         dv_cnt   = 0;
  int         fe_cnt   = 0;
  int         both_cnt = 0;
  logic [7:0] dv_data  = 8'h00;

  uart_rx #(
    .BR        (10_000),
    .CLKF      (1_600_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Counts strobe cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  = dv_cnt + 1;
      dv_data = data_out;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (data_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bclk);
    rx = 1'b0;
    clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clks(bclk);
    end
    rx = stop_bit;
    clks(bclk);
  endtask

  task automatic test_reset();
    clks(3);
    chk_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h exp 00", data_out); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_dv: got %b exp 0", data_valid); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe: got %b exp 0", frame_err); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
    reset = 1'b0;
    clks(20);
  endtask

  task automatic test_single();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, BITCLK);
    clks(5);
    chk_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL single_dv_cnt: got %0d exp 1", dv_cnt - dv0); else pass_cnt++;
    chk_cnt++; if (dv_data !== 8'h55) $display("FAIL single_dv_data: got %h exp 55", dv_data); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'h55) $display("FAIL single_data_out: got %h exp 55", data_out); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== fe0) $display("FAIL single_fe: got %0d exp %0d", fe_cnt, fe0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_busy: got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_cnt;
    send_frame(8'h00, 1'b1, BITCLK);
    chk_cnt++; if (dv_data !== 8'h00) $display("FAIL b2b_first: got %h exp 00", dv_data); else pass_cnt++;
    send_frame(8'hFF, 1'b1, BITCLK);
    clks(5);
    chk_cnt++; if (dv_cnt - dv0 !== 2) $display("FAIL b2b_dv_cnt: got %0d exp 2", dv_cnt - dv0); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'hFF) $display("FAIL b2b_second: got %h exp FF", data_out); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    clks(30);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL glitch_busy_hi: got %b exp 1", busy); else pass_cnt++;
    clks(20);
    rx = 1'b1;
    for (int i = 0; i < 90 && busy !== 1'b0; i++) clks(1);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_lo: got %b exp 0 within 90 clk", busy); else pass_cnt++;
    clks(200);
    chk_cnt++; if (dv_cnt !== dv0) $display("FAIL glitch_dv: got %0d exp %0d", dv_cnt, dv0); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== fe0) $display("FAIL glitch_fe: got %0d exp %0d", fe_cnt, fe0); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, BITCLK);
    clks(3 * BITCLK);
    chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_cnt: got %0d exp 1", fe_cnt - fe0); else pass_cnt++;
    chk_cnt++; if (dv_cnt !== dv0) $display("FAIL ferr_dv: got %0d exp %0d", dv_cnt, dv0); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'hFF) $display("FAIL ferr_data_hold: got %h exp FF", data_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b exp 1", busy); else pass_cnt++;
    rx = 1'b1;
    clks(BITCLK);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL ferr_idle: got %b exp 0", busy); else pass_cnt++;
    send_frame(8'h3C, 1'b1, BITCLK);
    clks(5);
    chk_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL ferr_next_dv: got %0d exp 1", dv_cnt - dv0); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'h3C) $display("FAIL ferr_next_data: got %h exp 3C", data_out); else pass_cnt++;
    chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_cnt_final: got %0d exp 1", fe_cnt - fe0); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int dv0;
    logic [7:0] b;
    b = 8'h81;
    rx = 1'b0;
    clks(BITCLK);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      clks(BITCLK);
    end
    rx = b[3];
    clks(80);
    reset = 1'b1;
    #1;
    chk_cnt++; if (data_out !== 8'h00) $display("FAIL rstmid_data: got %h exp 00", data_out); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL rstmid_dv: got %b exp 0", data_valid); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL rstmid_fe: got %b exp 0", frame_err); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else pass_cnt++;
    clks(5);
    rx = 1'b1;
    reset = 1'b0;
    dv0 = dv_cnt;
    clks(2 * BITCLK);
    chk_cnt++; if (dv_cnt !== dv0) $display("FAIL rstmid_discard: got %0d exp %0d", dv_cnt, dv0); else pass_cnt++;
    send_frame(8'h81, 1'b1, BITCLK);
    clks(5);
    chk_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL rstmid_next_dv: got %0d exp 1", dv_cnt - dv0); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'h81) $display("FAIL rstmid_next_data: got %h exp 81", data_out); else pass_cnt++;
  endtask

  task automatic test_stretched();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hC3, 1'b1, 165);
    clks(5);
    chk_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL slow_dv: got %0d exp 1", dv_cnt - dv0); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'hC3) $display("FAIL slow_data: got %h exp C3", data_out); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== fe0) $display("FAIL slow_fe: got %0d exp %0d", fe_cnt, fe0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_stretched();
    chk_cnt++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d exp 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
